// File: rtl/sine_dds_iq.sv
// Quadrature sine/cosine NCO: phase accumulator, offset, quarter-wave LUT and amplitude scaling.
// Four registered stages after the accumulator; one I/Q sample per clock.
module sine_dds_iq #(
  parameter int ACC_W   = 24,
  parameter int PHASE_W = 10,
  parameter int OUT_W   = 16,
  parameter int AMP_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    cfg_load,
  input  logic [ACC_W-1:0]        fcw_in,
  input  logic [ACC_W-1:0]        poff_in,
  input  logic [AMP_W-1:0]        amp_in,
  input  logic                    phase_sync,
  output logic signed [OUT_W-1:0] dds_sin,
  output logic signed [OUT_W-1:0] dds_cos,
  output logic                    out_valid
);

  localparam int LUT_AW = PHASE_W - 2;
  localparam int LUT_N  = 1 << LUT_AW;
  localparam int PW     = OUT_W + AMP_W + 1;
  localparam logic [AMP_W-1:0]          AMP_ONE  = {1'b1, {(AMP_W-1){1'b0}}};
  localparam logic [PHASE_W-1:0]        QTR      = {2'b01, {LUT_AW{1'b0}}};
  localparam logic signed [PW-1:0]      HALF_LSB = PW'(1) << (AMP_W - 2);

  // Half-LSB phase offset keeps the table free of zeros and exactly quarter-wave symmetric.
  function automatic logic [OUT_W-2:0] lut_value(input int idx);
    real ang;
    real v;
    ang = 2.0 * 3.14159265358979323846 * (real'(idx) + 0.5) / real'(1 << PHASE_W);
    v   = real'((1 << (OUT_W - 1)) - 1) * $sin(ang);
    return (OUT_W-1)'($rtoi(v + 0.5));
  endfunction

  logic [OUT_W-2:0] lut_rom [LUT_N];

  genvar gi;
  generate
    for (gi = 0; gi < LUT_N; gi++) begin : g_lut
      assign lut_rom[gi] = lut_value(gi);
    end
  endgenerate

  // Configuration and accumulator
  logic [ACC_W-1:0] acc_reg, fcw_reg, poff_reg;
  logic [AMP_W-1:0] amp_reg;
  logic             v0_reg;

  // Stage 1: truncated phase
  logic [PHASE_W-1:0] ph_sin_reg, ph_cos_reg;
  logic [AMP_W-1:0]   amp1_reg;
  logic               v1_reg;

  // Stage 2: LUT magnitude
  logic [OUT_W-2:0] mag_sin_reg, mag_cos_reg;
  logic             neg_sin_reg, neg_cos_reg;
  logic [AMP_W-1:0] amp2_reg;
  logic             v2_reg;

  // Stage 3: signed sample
  logic signed [OUT_W-1:0] s_sin_reg, s_cos_reg;
  logic [AMP_W-1:0]        amp3_reg;
  logic                    v3_reg;

  // Stage 4: scaled output
  logic signed [OUT_W-1:0] dds_sin_reg, dds_cos_reg;
  logic                    valid_reg;

  logic [AMP_W-1:0]        amp_clamped;
  logic [PHASE_W-1:0]      ph_sin_next, ph_cos_next;
  logic [LUT_AW-1:0]       idx_sin, idx_cos;
  logic signed [OUT_W-1:0] mag_sin_s, mag_cos_s;
  logic signed [PW-1:0]    rnd_sin, rnd_cos;
  logic signed [OUT_W-1:0] y_sin, y_cos;

  always_comb begin
    amp_clamped = (amp_in > AMP_ONE) ? AMP_ONE : amp_in;
    ph_sin_next = PHASE_W'((acc_reg + poff_reg) >> (ACC_W - PHASE_W));
    ph_cos_next = ph_sin_next + QTR;
    // Odd quadrants walk the quarter table backwards.
    idx_sin     = ph_sin_reg[LUT_AW-1:0] ^ {LUT_AW{ph_sin_reg[LUT_AW]}};
    idx_cos     = ph_cos_reg[LUT_AW-1:0] ^ {LUT_AW{ph_cos_reg[LUT_AW]}};
    mag_sin_s   = signed'({1'b0, mag_sin_reg});
    mag_cos_s   = signed'({1'b0, mag_cos_reg});
    rnd_sin     = PW'(s_sin_reg) * PW'(signed'({1'b0, amp3_reg})) + HALF_LSB;
    rnd_cos     = PW'(s_cos_reg) * PW'(signed'({1'b0, amp3_reg})) + HALF_LSB;
    y_sin       = OUT_W'(rnd_sin >>> (AMP_W - 1));
    y_cos       = OUT_W'(rnd_cos >>> (AMP_W - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg     <= '0;
      fcw_reg     <= '0;
      poff_reg    <= '0;
      amp_reg     <= AMP_ONE;
      v0_reg      <= 1'b0;
      ph_sin_reg  <= '0;
      ph_cos_reg  <= '0;
      amp1_reg    <= '0;
      v1_reg      <= 1'b0;
      mag_sin_reg <= '0;
      mag_cos_reg <= '0;
      neg_sin_reg <= 1'b0;
      neg_cos_reg <= 1'b0;
      amp2_reg    <= '0;
      v2_reg      <= 1'b0;
      s_sin_reg   <= '0;
      s_cos_reg   <= '0;
      amp3_reg    <= '0;
      v3_reg      <= 1'b0;
      dds_sin_reg <= '0;
      dds_cos_reg <= '0;
      valid_reg   <= 1'b0;
    end else begin
      // Accumulate with the fcw in effect before any same-cycle load.
      if (phase_sync) begin
        acc_reg <= '0;
      end else if (en) begin
        acc_reg <= acc_reg + fcw_reg;
      end
      if (cfg_load) begin
        fcw_reg  <= fcw_in;
        poff_reg <= poff_in;
        amp_reg  <= amp_clamped;
      end
      v0_reg      <= en;

      ph_sin_reg  <= ph_sin_next;
      ph_cos_reg  <= ph_cos_next;
      amp1_reg    <= amp_reg;
      v1_reg      <= v0_reg;

      mag_sin_reg <= lut_rom[idx_sin];
      mag_cos_reg <= lut_rom[idx_cos];
      neg_sin_reg <= ph_sin_reg[PHASE_W-1];
      neg_cos_reg <= ph_cos_reg[PHASE_W-1];
      amp2_reg    <= amp1_reg;
      v2_reg      <= v1_reg;

      s_sin_reg   <= neg_sin_reg ? -mag_sin_s : mag_sin_s;
      s_cos_reg   <= neg_cos_reg ? -mag_cos_s : mag_cos_s;
      amp3_reg    <= amp2_reg;
      v3_reg      <= v2_reg;

      dds_sin_reg <= y_sin;
      dds_cos_reg <= y_cos;
      valid_reg   <= v3_reg;
    end
  end

  assign dds_sin   = dds_sin_reg;
  assign dds_cos   = dds_cos_reg;
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_sine_dds_iq.sv
// Self-checking bench for sine_dds_iq: a reference model pushes each expected sample to a
// queue at the edge that produces it; the DUT output four edges later is popped and compared.
module tb_sine_dds_iq;

  localparam real PI = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               reset, en, cfg_load, phase_sync;
  logic [23:0]        fcw_in, poff_in;
  logic [15:0]        amp_in;
  logic signed [15:0] dds_sin, dds_cos;
  logic               out_valid;

  always #5 clk = ~clk;

  sine_dds_iq #(.ACC_W(24), .PHASE_W(10), .OUT_W(16), .AMP_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_load(cfg_load),
    .fcw_in(fcw_in), .poff_in(poff_in), .amp_in(amp_in), .phase_sync(phase_sync),
    .dds_sin(dds_sin), .dds_cos(dds_cos), .out_valid(out_valid)
  );

  typedef struct {int s; int c; bit v;} sample_t;

  sample_t exp_q[$];
  int      cap_sin[$];
  int      cap_cos[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  longint  m_acc = 0, m_fcw = 0, m_poff = 0, m_amp = 32768;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Direct evaluation of the table formula over the full circle, rounded symmetrically.
  function automatic int ref_lut(input int p);
    real r;
    r = 32767.0 * $sin(2.0 * PI * (real'(p) + 0.5) / 1024.0);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction

  function automatic int ref_scale(input int s, input longint amp);
    longint t;
    t = longint'(s) * amp + 64'sd16384;
    return int'(t >>> 15);
  endfunction

  task automatic tick();
    sample_t e;
    int      p;
    @(posedge clk);
    if (reset) begin
      m_acc = 0; m_fcw = 0; m_poff = 0; m_amp = 32768;
      exp_q.delete();
      repeat (4) exp_q.push_back('{0, 0, 1'b0});
    end else begin
      if (phase_sync) m_acc = 0;
      else if (en)    m_acc = (m_acc + m_fcw) & 64'hFF_FFFF;
      if (cfg_load) begin
        m_fcw  = fcw_in;
        m_poff = poff_in;
        m_amp  = (amp_in > 16'h8000) ? 32768 : amp_in;
      end
    end
    p   = int'(((m_acc + m_poff) & 64'hFF_FFFF) >> 14);
    e.s = ref_scale(ref_lut(p), m_amp);
    e.c = ref_scale(ref_lut((p + 256) % 1024), m_amp);
    e.v = en && !reset;
    exp_q.push_back(e);
    #1;
    if (exp_q.size() > 4) begin
      e = exp_q.pop_front();
      check("sb_sin", dds_sin, e.s);
      check("sb_cos", dds_cos, e.c);
      check("sb_valid", out_valid, e.v);
    end
    if (out_valid) begin
      cap_sin.push_back(dds_sin);
      cap_cos.push_back(dds_cos);
    end
  endtask

  // Drain the pipeline, load and sync together, then enable.
  task automatic start_tone(input logic [23:0] f, input logic [23:0] p, input logic [15:0] a);
    en = 1'b0;
    repeat (5) tick();
    cfg_load = 1'b1; phase_sync = 1'b1;
    fcw_in = f; poff_in = p; amp_in = a;
    tick();
    cfg_load = 1'b0; phase_sync = 1'b0; en = 1'b1;
    cap_sin.delete();
    cap_cos.delete();
  endtask

  task automatic run_valid(input int n);
    int guard;
    guard = 0;
    while (cap_sin.size() < n && guard < 50) begin
      tick();
      guard++;
    end
    check("valid_budget", cap_sin.size() >= n, 1);
  endtask

  // First captured sample comes from acc = fcw, i.e. table position 1.
  task automatic check_seq(input string tag, input bit use_cos,
                           input int a, input int b, input int c, input int d);
    int t[4];
    t = '{a, b, c, d};
    for (int k = 0; k < 8; k++)
      check(tag, use_cos ? cap_cos[k] : cap_sin[k], t[(k + 1) % 4]);
  endtask

  initial begin
    int first;
    int inval;
    reset = 1'b1; en = 1'b0; cfg_load = 1'b0; phase_sync = 1'b0;
    fcw_in = '0; poff_in = '0; amp_in = '0;
    tick();
    tick();
    check("rst_sin", dds_sin, 0);
    check("rst_cos", dds_cos, 0);
    check("rst_valid", out_valid, 0);
    reset = 1'b0;

    start_tone(24'h400000, 24'h0, 16'h8000);
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (out_valid && first == 0) first = k;
    end
    check("first_valid_lat", first - 1, 4);
    run_valid(8);
    check_seq("quarter_sin", 1'b0, 101, 32767, -101, -32767);
    check_seq("quarter_cos", 1'b1, 32767, -101, -32767, 101);

    start_tone(24'h400000, 24'h0, 16'h4000);
    run_valid(8);
    check_seq("half_amp_sin", 1'b0, 51, 16384, -50, -16383);

    start_tone(24'h400000, 24'h0, 16'hFFFF);
    run_valid(8);
    check_seq("clamp_sin", 1'b0, 101, 32767, -101, -32767);

    start_tone(24'h400000, 24'h400000, 16'h8000);
    run_valid(8);
    check_seq("poff_sin", 1'b0, 32767, -101, -32767, 101);

    start_tone(24'h07AE14, 24'h0, 16'h8000);
    repeat (10) tick();
    phase_sync = 1'b1; cfg_load = 1'b1; fcw_in = 24'h100000;
    tick();
    phase_sync = 1'b0; cfg_load = 1'b0;
    repeat (4) tick();
    check("psync_sin", dds_sin, 101);
    check("psync_cos", dds_cos, 32767);
    check("psync_valid", out_valid, 1);

    inval = 0;
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (!out_valid) inval++;
    end
    en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (!out_valid) inval++;
    end
    check("gate_invalid_cnt", inval, 5);

    start_tone(24'hFFFFFF, 24'h0, 16'h4000);
    run_valid(4);
    check("wrap_first_sin", cap_sin[0], -50);
    check("wrap_second_sin", cap_sin[1], -50);
    reset = 1'b1;
    tick();
    check("mid_rst_sin", dds_sin, 0);
    check("mid_rst_cos", dds_cos, 0);
    check("mid_rst_valid", out_valid, 0);
    reset = 1'b0; en = 1'b1;
    repeat (5) tick();
    check("amp_reset_sin", dds_sin, 101);
    check("amp_reset_cos", dds_cos, 32767);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
